servo_pwm_driver: RTL and testbench
===================================

SERVO_PWM_DRIVER -- requirements
Module: servo_pwm_driver

Interface
REQ-001 Parameter TICK_DIV, default 65: clock cycles per 1 us time-base tick.
REQ-002 Parameter FRAME_US, default 20000: PWM frame length in ticks.
REQ-003 Parameter MIN_PULSE_US, default 1000: pulse width in ticks for command 0.
REQ-004 Parameter PULSE_SHIFT, default 2: right shift applied to command before it is added to MIN_PULSE_US.
REQ-005 Parameter SLEW_STEP, default 64: maximum command change per frame, used only when slew limiting is compiled in.
REQ-006 clock  input  1: single system clock; all logic is on the rising edge.
REQ-007 reset_n  input  1: reset, asynchronous and active-low.
REQ-008 command  input  12: unsigned servo command from the position controller.
REQ-009 i_val  input  1: one-cycle strobe; command is valid in that cycle.
REQ-010 pwm_out  output  1: servo PWM signal.
REQ-011 frame_start  output  1: one-cycle pulse in the first cycle of each frame.
REQ-012 active_cmd  output  12: command value applied in the current frame.
REQ-013 armed  output  1: high once the first command has been accepted after reset.

Function
REQ-014 Tick prescaler SHALL count 0..TICK_DIV-1 and SHALL assert an internal tick when it wraps.
REQ-015 The frame counter SHALL count ticks 0..FRAME_US-1 and then wrap to 0.
REQ-016 The state machine SHALL have three states: IDLE, HIGH and LOW.
REQ-017 IDLE: pwm_out=0 and no frame activity; the first i_val SHALL move the FSM to HIGH at the next tick boundary, with frame counter=0.
REQ-018 HIGH: pwm_out=1; the FSM SHALL move to LOW when frame count = MIN_PULSE_US + (active_cmd >> PULSE_SHIFT).
REQ-019 LOW: pwm_out=0; at frame wrap the FSM SHALL move to HIGH and frame_start SHALL pulse.
REQ-020 On i_val, command SHALL be captured into a pending register and a pending flag SHALL be set; a later i_val before the frame start SHALL overwrite it, so the latest command wins.
REQ-021 At frame start, if the pending flag is set, active_cmd SHALL load the pending value and the pending flag SHALL clear; otherwise active_cmd SHALL hold.
REQ-022 If i_val coincides with the frame-start cycle, the new value SHALL become pending for the next frame and SHALL NOT be applied in the current frame.
REQ-023 A command change SHALL never alter the pulse width mid-frame.
REQ-024 Pulse-width arithmetic SHALL be unsigned and at least 16 bits wide; FRAME_US > MIN_PULSE_US + (4095 >> PULSE_SHIFT) is a legal-parameter precondition.
REQ-025 armed SHALL set on the first accepted i_val and stay set until reset.

Reset
REQ-026 While reset_n=0, outputs SHALL be pwm_out=0, frame_start=0, active_cmd=0, armed=0.
REQ-027 While reset_n=0, the FSM SHALL be in IDLE, all counters SHALL be 0 and the pending flag SHALL be clear.
REQ-028 Reset asserted mid-pulse SHALL drive pwm_out low immediately, without waiting for a clock edge.

Configuration
REQ-029 Macro SERVO_SLEW_LIMIT_EN defined: at frame start, active_cmd SHALL move toward the pending value by at most SLEW_STEP, saturating at the target.
REQ-030 With SERVO_SLEW_LIMIT_EN defined, the pending value SHALL be retained until active_cmd reaches it.
REQ-031 Macro SERVO_SLEW_LIMIT_EN defined: the first command after reset SHALL load directly, without slewing.
REQ-032 Macro SERVO_SLEW_LIMIT_EN undefined: active_cmd SHALL load the pending value in full at frame start.

Verification
Bench parameters: TICK_DIV=2, FRAME_US=100, MIN_PULSE_US=10, PULSE_SHIFT=7, SLEW_STEP=512.
REQ-033 After reset, no i_val for 500 cycles -> pwm_out=0, armed=0, frame_start never pulses.
REQ-034 i_val with command=0 -> armed=1; pwm_out high for 20 cycles in every 200-cycle frame.
REQ-035 i_val with command=4095 -> high time 82 cycles (41 ticks).
REQ-036 i_val with command=2048 during HIGH of a 0 frame -> current frame still 20 cycles high, next frame 52 cycles high.
REQ-037 Two i_val strobes in one frame (1000, then 3000) -> next frame uses 3000, i.e. 2*(10+23)=66 cycles high.
REQ-038 reset_n pulled low mid-HIGH -> pwm_out=0 in the same cycle; after release the FSM is in IDLE until the next i_val.
REQ-039 SERVO_SLEW_LIMIT_EN defined, active 0 -> 2048 -> active_cmd steps 512, 1024, 1536, 2048 on successive frame starts.

Source files
------------

// File: rtl/servo_pwm_driver.sv
// Servo PWM generator: 1 us tick prescaler, frame counter and IDLE/HIGH/LOW FSM.
// Optional slew limiting of active_cmd is compiled in with `define SERVO_SLEW_LIMIT_EN.
module servo_pwm_driver #(
   parameter int unsigned TICK_DIV     = 65,
   parameter int unsigned FRAME_US     = 20000,
   parameter int unsigned MIN_PULSE_US = 1000,
   parameter int unsigned PULSE_SHIFT  = 2,
   parameter int unsigned SLEW_STEP    = 64
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [11:0] command,
   input  logic        i_val,
   output logic        pwm_out,
   output logic        frame_start,
   output logic [11:0] active_cmd,
   output logic        armed
);

   localparam int unsigned  PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [15:0]  FRAME_LAST = 16'(FRAME_US - 1);
   localparam logic [15:0]  MIN_W      = 16'(MIN_PULSE_US);

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } state_t;

   state_t        state_q;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick;
   logic [15:0]   frame_q;
   logic [15:0]   frame_inc;
   logic [15:0]   width;
   logic [11:0]   pend_q;
   logic          pend_valid_q;
   logic [11:0]   active_q;
   logic [11:0]   active_d;
   logic          pend_keep;
   logic          pwm_q;
   logic          fstart_q;
   logic          armed_q;

   assign tick      = (presc_q == TICK_LAST);
   assign frame_inc = frame_q + 16'd1;
   assign width     = MIN_W + (16'(active_q) >> PULSE_SHIFT);

   always_comb begin
      presc_d = tick ? '0 : presc_q + 1'b1;
   end

`ifdef SERVO_SLEW_LIMIT_EN
   localparam logic [11:0] STEP = (SLEW_STEP > 4095) ? 12'd4095 : 12'(SLEW_STEP);

   // The first load out of IDLE is direct; later loads move at most STEP and keep the target pending.
   always_comb begin
      active_d  = pend_q;
      pend_keep = 1'b0;
      if (state_q != IDLE) begin
         if (pend_q > active_q) begin
            if ((pend_q - active_q) > STEP) begin
               active_d  = active_q + STEP;
               pend_keep = 1'b1;
            end
         end else if ((active_q - pend_q) > STEP) begin
            active_d  = active_q - STEP;
            pend_keep = 1'b1;
         end
      end
   end
`else
   always_comb begin
      active_d  = pend_q;
      pend_keep = 1'b0;
   end
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         presc_q      <= '0;
         frame_q      <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         active_q     <= '0;
         pwm_q        <= 1'b0;
         fstart_q     <= 1'b0;
         armed_q      <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         fstart_q <= 1'b0;
         if (i_val) begin
            pend_q       <= command;
            pend_valid_q <= 1'b1;
            armed_q      <= 1'b1;
         end
         // A strobe in the load cycle itself stays pending for the following frame.
         if (tick) begin
            unique case (state_q)
               IDLE: begin
                  if (pend_valid_q) begin
                     state_q  <= HIGH;
                     frame_q  <= '0;
                     pwm_q    <= 1'b1;
                     fstart_q <= 1'b1;
                     active_q <= active_d;
                     if (!i_val) pend_valid_q <= 1'b0;
                  end
               end
               HIGH: begin
                  frame_q <= frame_inc;
                  if (frame_inc >= width) begin
                     state_q <= LOW;
                     pwm_q   <= 1'b0;
                  end
               end
               LOW: begin
                  if (frame_q == FRAME_LAST) begin
                     state_q  <= HIGH;
                     frame_q  <= '0;
                     pwm_q    <= 1'b1;
                     fstart_q <= 1'b1;
                     if (pend_valid_q) begin
                        active_q <= active_d;
                        if (!i_val && !pend_keep) pend_valid_q <= 1'b0;
                     end
                  end else begin
                     frame_q <= frame_inc;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  pwm_q   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign pwm_out     = pwm_q;
   assign frame_start = fstart_q;
   assign active_cmd  = active_q;
   assign armed       = armed_q;

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Directed self-checking bench for servo_pwm_driver (TICK_DIV=2, FRAME_US=100, MIN=10, SHIFT=7).
module tb_servo_pwm_driver;

   logic        clock;
   logic        reset_n;
   logic [11:0] command;
   logic        i_val;
   logic        pwm_out;
   logic        frame_start;
   logic [11:0] active_cmd;
   logic        armed;

   int checks = 0;
   int errors = 0;

   servo_pwm_driver #(
      .TICK_DIV    (2),
      .FRAME_US    (100),
      .MIN_PULSE_US(10),
      .PULSE_SHIFT (7),
      .SLEW_STEP   (512)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .command    (command),
      .i_val      (i_val),
      .pwm_out    (pwm_out),
      .frame_start(frame_start),
      .active_cmd (active_cmd),
      .armed      (armed)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic strobe(input logic [11:0] c);
      @(negedge clock);
      i_val   = 1'b1;
      command = c;
      @(negedge clock);
      i_val   = 1'b0;
   endtask

   task automatic wait_fs(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (frame_start === 1'b1) seen = 1'b1;
         else @(negedge clock);
      end
   endtask

   // Entered on the frame-start cycle; returns on the next frame-start cycle.
   task automatic measure_frame(input int s1_at, input logic [11:0] s1_cmd,
                                input int s2_at, input logic [11:0] s2_cmd,
                                output int hi, output int len);
      hi  = 0;
      len = 0;
      do begin
         if (len == s1_at) begin
            i_val   = 1'b1;
            command = s1_cmd;
         end else if (len == s2_at) begin
            i_val   = 1'b1;
            command = s2_cmd;
         end else begin
            i_val = 1'b0;
         end
         if (pwm_out === 1'b1) hi++;
         len++;
         @(negedge clock);
      end while (frame_start !== 1'b1 && len < 1000);
      i_val = 1'b0;
   endtask

   task automatic idle_watch(input string tag);
      int fs_n;
      int hi_n;
      fs_n = 0;
      hi_n = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clock);
         if (frame_start !== 1'b0) fs_n++;
         if (pwm_out !== 1'b0) hi_n++;
      end
      chk({tag, "_fs_pulses"}, fs_n, 0);
      chk({tag, "_pwm_high"}, hi_n, 0);
      chk({tag, "_armed"}, armed, 0);
   endtask

   initial begin
      bit seen;
      int hi;
      int len;
      int exp_act [4] = '{512, 1024, 1536, 2048};
      int exp_hi  [4] = '{28, 36, 44, 52};

      reset_n = 1'b0;
      i_val   = 1'b0;
      command = '0;
      repeat (3) @(negedge clock);
      chk("rst_pwm", pwm_out, 0);
      chk("rst_fs", frame_start, 0);
      chk("rst_active", active_cmd, 0);
      chk("rst_armed", armed, 0);
      reset_n = 1'b1;

      idle_watch("idle");

      strobe(12'd0);
      chk("arm_after_cmd0", armed, 1);
      wait_fs(seen);
      chk("first_frame_start", seen, 1);
      chk("first_pwm_high", pwm_out, 1);
      chk("f1_active", active_cmd, 0);
      measure_frame(-1, '0, -1, '0, hi, len);
      chk("f1_hi_cmd0", hi, 20);
      chk("f1_len", len, 200);

`ifdef SERVO_SLEW_LIMIT_EN
      measure_frame(5, 12'd2048, -1, '0, hi, len);
      chk("f2_hi_cmd0", hi, 20);
      for (int k = 0; k < 4; k++) begin
         chk("slew_active", active_cmd, exp_act[k]);
         measure_frame(-1, '0, -1, '0, hi, len);
         chk("slew_hi", hi, exp_hi[k]);
      end
      chk("slew_settled", active_cmd, 2048);
`else
      measure_frame(0, 12'd4095, -1, '0, hi, len);
      chk("f2_hi_fs_strobe_deferred", hi, 20);
      chk("f3_active", active_cmd, 4095);
      measure_frame(100, 12'd0, -1, '0, hi, len);
      chk("f3_hi_cmd4095", hi, 82);
      chk("f3_len", len, 200);
      chk("f4_active", active_cmd, 0);
      measure_frame(5, 12'd2048, -1, '0, hi, len);
      chk("f4_hi_midhigh_cmd", hi, 20);
      chk("f5_active", active_cmd, 2048);
      measure_frame(10, 12'd1000, 150, 12'd3000, hi, len);
      chk("f5_hi_cmd2048", hi, 52);
      chk("f6_active_latest", active_cmd, 3000);
      measure_frame(-1, '0, -1, '0, hi, len);
      chk("f6_hi_cmd3000", hi, 66);
      chk("f7_active_hold", active_cmd, 3000);
`endif

      repeat (3) @(negedge clock);
      chk("pre_reset_pwm_high", pwm_out, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_pwm", pwm_out, 0);
      chk("async_rst_active", active_cmd, 0);
      chk("async_rst_armed", armed, 0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;

      idle_watch("post_rst");

      strobe(12'd4095);
      chk("rearm", armed, 1);
      wait_fs(seen);
      chk("rearm_frame_start", seen, 1);
      chk("rearm_active_direct", active_cmd, 4095);
      measure_frame(-1, '0, -1, '0, hi, len);
      chk("rearm_hi_cmd4095", hi, 82);
      chk("rearm_len", len, 200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
